// File: rtl/uart_board_if.sv
// uart_board_if: byte stream from the UART receiver into the board assembler,
// and the assembled board with its status strobes going back out.
interface uart_board_if #(
  parameter int BOARD_BITS = 162
);
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [BOARD_BITS-1:0] board_out;
  logic                  board_valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output rx_data, rx_ready,
    input  board_out, board_valid, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_ready,
    output board_out, board_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_board_assembler.sv
// uart_board_assembler: collects SYNC + payload bytes from the UART receiver
// into a board vector and commits it once the frame is complete.
// Optional feature macro: CHECKSUM_EN (adds a trailing XOR checksum byte).
//
// state   | meaning
// HUNT    | waiting for SYNC_BYTE, other bytes dropped
// PAYLOAD | storing payload bytes into the shift buffer
// CHECK   | waiting for checksum byte (CHECKSUM_EN builds only)
// COMMIT  | one cycle: copy buffer to board_out, pulse board_valid
module uart_board_assembler #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         BOARD_BITS  = 162,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  uart_board_if.slave bus
);
  localparam int PAYLOAD_BYTES = (BOARD_BITS + 7) / 8;
  localparam int IDXW          = $clog2(PAYLOAD_BYTES);
  localparam int TW            = $clog2(TIMEOUT_CYC);
  localparam int PW            = IDXW + 3;

  localparam logic [3:0] HUNT    = 4'b0001;
  localparam logic [3:0] PAYLOAD = 4'b0010;
`ifdef CHECKSUM_EN
  localparam logic [3:0] CHECK   = 4'b0100;
`endif
  localparam logic [3:0] COMMIT  = 4'b1000;

  logic [3:0]            state;
  logic                  rdy_last;
  logic [IDXW-1:0]       idx;
  logic [TW-1:0]         tcnt;
  logic [BOARD_BITS-1:0] buffer;
  logic [BOARD_BITS-1:0] buf_next;
  logic [BOARD_BITS-1:0] board_q;
  logic                  valid_q;
  logic                  err_q;
  logic [PW-1:0]         bit_pos;
`ifdef CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic byte_stb;
  logic last_idx;
  logic timeout_hit;

  assign byte_stb    = bus.rx_ready & ~rdy_last;
  assign last_idx    = (idx == IDXW'(PAYLOAD_BYTES - 1));
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1)) & ~byte_stb;

  // Merge the incoming byte into the buffer at slot idx; bits past the board
  // width (upper bits of the last byte) are dropped.
  always_comb begin
    buf_next = buffer;
    bit_pos  = '0;
    for (int b = 0; b < 8; b++) begin
      bit_pos = {idx, 3'b000} + PW'(b);
      if (int'(bit_pos) < BOARD_BITS) buf_next[bit_pos] = bus.rx_data[b];
    end
  end

  // Frame FSM, inter-byte timeout and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= HUNT;
      rdy_last <= 1'b1;
      idx      <= '0;
      tcnt     <= '0;
      buffer   <= '0;
      board_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      rdy_last <= bus.rx_ready;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;

      if (byte_stb)
        tcnt <= '0;
`ifdef CHECKSUM_EN
      else if (state == PAYLOAD || state == CHECK)
`else
      else if (state == PAYLOAD)
`endif
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      case (state)
        HUNT: begin
          if (byte_stb && bus.rx_data == SYNC_BYTE) begin
            state  <= PAYLOAD;
            idx    <= '0;
            buffer <= '0;
`ifdef CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (byte_stb) begin
            buffer <= buf_next;
            idx    <= idx + 1'b1;
`ifdef CHECKSUM_EN
            csum   <= csum ^ bus.rx_data;
            if (last_idx) state <= CHECK;
`else
            if (last_idx) state <= COMMIT;
`endif
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= HUNT;
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          if (byte_stb) begin
            if (bus.rx_data == csum) begin
              state <= COMMIT;
            end else begin
              err_q <= 1'b1;
              state <= HUNT;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= HUNT;
          end
        end
`endif
        COMMIT: begin
          board_q <= buffer;
          valid_q <= 1'b1;
          state   <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.board_out   = board_q;
  assign bus.board_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state != HUNT);
endmodule
